// File: rtl/divisor_ctrl_4b_pkg.sv
// Shared types and constants for the button-driven 4-bit divider controller.
// Provides operand width, FSM state encoding, the error LED pattern and a
// small wrap-around increment/decrement helper used by both edit states.
package divisor_pkg;

  localparam int W = 4;

  typedef enum logic [2:0] {
    S_NUM    = 3'd0,
    S_DEN    = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_SHOW_Q = 3'd4,
    S_SHOW_R = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [W-1:0] LED_ERR = 4'hF;

  // Modulo-2^W step; simultaneous up and down cancel out.
  function automatic logic [W-1:0] step_val(input logic [W-1:0] v,
                                            input logic inc,
                                            input logic dec);
    logic [W-1:0] r;
    r = v;
    if (inc && !dec) r = v + 1'b1;
    else if (dec && !inc) r = v - 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/divisor_ctrl_4b_if.sv
// Start/done handshake between the controller and the iterative divider datapath.
// master (controller): drives dv_start/dv_num/dv_den, receives dv_done/dv_quo/dv_rem.
// slave (datapath): the mirror image. Operands stay stable from start until done.
interface divisor_ctrl_4b_if #(
  parameter int W = 4
);
  logic         dv_start;
  logic [W-1:0] dv_num;
  logic [W-1:0] dv_den;
  logic         dv_done;
  logic [W-1:0] dv_quo;
  logic [W-1:0] dv_rem;

  modport master (
    output dv_start, dv_num, dv_den,
    input  dv_done, dv_quo, dv_rem
  );

  modport slave (
    input  dv_start, dv_num, dv_den,
    output dv_done, dv_quo, dv_rem
  );
endinterface

// File: rtl/divisor_ctrl_4b_btn_cond.sv
// Button conditioner: 2-flop synchronizer, optional debounce, rising-edge pulse.
// Latency: registered 1-cycle press pulse 3 cycles after the raw edge (3+DEB_CYCLES with DEBOUNCE_EN).
// Ports: clk, rst (async active-low), raw (button), press (1-cycle pulse). Macro: DEBOUNCE_EN.
module btn_cond #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  logic sync1, sync2;
  logic level;
  logic level_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic          deb_level;
  logic [DW-1:0] deb_cnt;

  // Count consecutive synced samples that disagree with the accepted level;
  // the new level is taken on the DEB_CYCLES-th such sample in a row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else if (sync2 != deb_level) begin
      if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
        deb_level <= sync2;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  assign level = deb_level;
`else
  logic deb_unused;
  assign deb_unused = (DEB_CYCLES == 0);
  assign level      = sync2;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/divisor_ctrl_4b.sv
// Sequencer for the button-driven 4-bit divider: edit num/den, launch datapath, show quo/rem.
// Latency: state and registered outputs update the cycle after a press pulse; dv_start is 1 cycle.
// Ports: clk, rst (async active-low), up/down/ok buttons, leds/busy/err, dv (datapath master). Macro: DEBOUNCE_EN.
module divisor_ctrl_4b
  import divisor_pkg::*;
#(
  parameter int TIMEOUT    = 32,
  parameter int DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  input  logic             ok,
  output logic [W-1:0]     leds,
  output logic             busy,
  output logic             err,
  divisor_ctrl_4b_if.master dv
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic up_p, down_p, ok_p;

  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_up (
    .clk(clk), .rst(rst), .raw(up), .press(up_p)
  );
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_down (
    .clk(clk), .rst(rst), .raw(down), .press(down_p)
  );
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_ok (
    .clk(clk), .rst(rst), .raw(ok), .press(ok_p)
  );

  state_t             state, state_nxt;
  logic [W-1:0]       num, num_nxt;
  logic [W-1:0]       den, den_nxt;
  logic [W-1:0]       quo_r, quo_nxt;
  logic [W-1:0]       rem_r, rem_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [W-1:0]       leds_nxt;
  logic               busy_nxt, err_nxt, start_nxt;
  logic               start_q;

  assign dv.dv_start = start_q;
  assign dv.dv_num   = num;
  assign dv.dv_den   = den;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_NUM;
      num     <= '0;
      den     <= '0;
      quo_r   <= '0;
      rem_r   <= '0;
      cnt     <= '0;
      leds    <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      num     <= num_nxt;
      den     <= den_nxt;
      quo_r   <= quo_nxt;
      rem_r   <= rem_nxt;
      cnt     <= cnt_nxt;
      leds    <= leds_nxt;
      busy    <= busy_nxt;
      err     <= err_nxt;
      start_q <= start_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    num_nxt   = num;
    den_nxt   = den;
    quo_nxt   = quo_r;
    rem_nxt   = rem_r;
    cnt_nxt   = cnt;

    case (state)
      S_NUM: begin
        num_nxt = step_val(num, up_p, down_p);
        if (ok_p) begin
          state_nxt = S_DEN;
          den_nxt   = '0;
        end
      end
      S_DEN: begin
        den_nxt = step_val(den, up_p, down_p);
        // The zero check uses the value the user saw when pressing ok.
        if (ok_p) state_nxt = (den == '0) ? S_ERR : S_START;
      end
      S_START: begin
        state_nxt = S_WAIT;
        cnt_nxt   = '0;
      end
      S_WAIT: begin
        // A completion arriving on the expiry cycle still counts as success.
        if (dv.dv_done) begin
          quo_nxt   = dv.dv_quo;
          rem_nxt   = dv.dv_rem;
          state_nxt = S_SHOW_Q;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_nxt = S_ERR;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_SHOW_Q: if (ok_p) state_nxt = S_SHOW_R;
      S_SHOW_R: if (ok_p) state_nxt = S_NUM;
      S_ERR: begin
        if (ok_p) begin
          state_nxt = S_DEN;
          den_nxt   = '0;
        end
      end
      default: state_nxt = S_NUM;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state register instead of trailing it by a cycle.
  always_comb begin
    leds_nxt  = '0;
    busy_nxt  = 1'b0;
    err_nxt   = 1'b0;
    start_nxt = 1'b0;
    case (state_nxt)
      S_NUM:    leds_nxt = num_nxt;
      S_DEN:    leds_nxt = den_nxt;
      S_START: begin
        leds_nxt  = den_nxt;
        busy_nxt  = 1'b1;
        start_nxt = 1'b1;
      end
      S_WAIT: begin
        leds_nxt = den_nxt;
        busy_nxt = 1'b1;
      end
      S_SHOW_Q: leds_nxt = quo_nxt;
      S_SHOW_R: leds_nxt = rem_nxt;
      S_ERR: begin
        leds_nxt = LED_ERR;
        err_nxt  = 1'b1;
      end
      default:  leds_nxt = '0;
    endcase
  end

endmodule

// File: tb/tb_divisor_ctrl_4b.sv
// Self-checking bench for divisor_ctrl_4b with a datapath model (done 4 cycles after start).
// Drives buttons through press sequences and compares against an arithmetic model of num/den.
// Build with DEBOUNCE_EN defined to also exercise the debounce glitch filter.
module tb_divisor_ctrl_4b;

  localparam int TIMEOUT    = 32;
  localparam int DEB_CYCLES = 16;
`ifdef DEBOUNCE_EN
  localparam int HOLD   = DEB_CYCLES + 4;
  localparam int SETTLE = DEB_CYCLES + 4;
`else
  localparam int HOLD   = 4;
  localparam int SETTLE = 4;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       up, down, ok;
  logic [3:0] leds;
  logic       busy, err;

  divisor_ctrl_4b_if #(.W(4)) dv_if ();

  divisor_ctrl_4b #(.TIMEOUT(TIMEOUT), .DEB_CYCLES(DEB_CYCLES)) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .ok(ok),
    .leds(leds), .busy(busy), .err(err), .dv(dv_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state
  int         m_num = 0;
  int         m_den = 0;
  bit         dp_en = 1'b1;
  int         starts = 0;
  logic [3:0] cap_num, cap_den;

  // Divider datapath model
  initial begin
    dv_if.dv_done = 1'b0;
    dv_if.dv_quo  = '0;
    dv_if.dv_rem  = '0;
    forever begin
      @(negedge clk);
      if (dv_if.dv_start === 1'b1) begin
        starts++;
        cap_num = dv_if.dv_num;
        cap_den = dv_if.dv_den;
        if (dp_en) begin
          repeat (4) @(posedge clk);
          #1;
          dv_if.dv_done = 1'b1;
          dv_if.dv_quo  = (cap_den == 0) ? 4'd0 : cap_num / cap_den;
          dv_if.dv_rem  = (cap_den == 0) ? 4'd0 : cap_num % cap_den;
          @(posedge clk);
          #1;
          dv_if.dv_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic press(input bit u, input bit d, input bit o);
    @(negedge clk);
    up = u; down = d; ok = o;
    repeat (HOLD) @(negedge clk);
    up = 1'b0; down = 1'b0; ok = 1'b0;
    repeat (SETTLE) @(negedge clk);
  endtask

  // Walk the edited value to target via up or down presses, modelled modulo 16.
  task automatic move_val(input int target, input bit is_den);
    int cur, n;
    bit go_up;
    cur   = is_den ? m_den : m_num;
    go_up = $urandom_range(0, 1);
    n     = go_up ? ((target - cur + 16) % 16) : ((cur - target + 16) % 16);
    for (int i = 0; i < n; i++) begin
      press(go_up, !go_up, 1'b0);
      cur = go_up ? (cur + 1) % 16 : (cur + 15) % 16;
    end
    if (is_den) m_den = cur; else m_num = cur;
    checks++;
    if (leds !== cur[3:0]) begin
      failures++;
      $display("FAIL move_val leds=%0d expected=%0d", leds, cur);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    m_num = 0;
    m_den = 0;
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (dv_if.dv_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // From S_DEN with a nonzero den: launch, check quotient then remainder, return to S_NUM.
  task automatic run_division(input string tag);
    int s0;
    s0 = starts;
    press(1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checks++;
    if (starts !== s0 + 1) begin
      failures++;
      $display("FAIL %s start_count got=%0d expected=%0d", tag, starts - s0, 1);
    end
    checks++;
    if (cap_num !== m_num[3:0] || cap_den !== m_den[3:0]) begin
      failures++;
      $display("FAIL %s operands got=%0d/%0d expected=%0d/%0d", tag, cap_num, cap_den, m_num, m_den);
    end
    checks++;
    if (leds !== 4'(m_num / m_den) || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s quotient leds=%0d busy=%b expected=%0d busy=0", tag, leds, busy, m_num / m_den);
    end
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (leds !== 4'(m_num % m_den)) begin
      failures++;
      $display("FAIL %s remainder leds=%0d expected=%0d", tag, leds, m_num % m_den);
    end
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (leds !== m_num[3:0] || err !== 1'b0) begin
      failures++;
      $display("FAIL %s back_to_num leds=%0d err=%b expected=%0d err=0", tag, leds, err, m_num);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; up = 1'b0; down = 1'b0; ok = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (leds !== 4'd0 || busy !== 1'b0 || err !== 1'b0 || dv_if.dv_start !== 1'b0) begin
      failures++;
      $display("FAIL reset leds=%0d busy=%b err=%b start=%b expected all zero",
               leds, busy, err, dv_if.dv_start);
    end
    checks++;
    if (dv_if.dv_num !== 4'd0 || dv_if.dv_den !== 4'd0) begin
      failures++;
      $display("FAIL reset_operands num=%0d den=%0d expected=0/0", dv_if.dv_num, dv_if.dv_den);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    repeat (4) press(1'b1, 1'b0, 1'b0);
    m_num = 4;
    checks++;
    if (leds !== 4'd4) begin
      failures++;
      $display("FAIL basic_num leds=%0d expected=4", leds);
    end
    press(1'b0, 1'b0, 1'b1);
    m_den = 0;
    checks++;
    if (leds !== 4'd0) begin
      failures++;
      $display("FAIL basic_den_clear leds=%0d expected=0", leds);
    end
    repeat (5) press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    m_den = 4;
    checks++;
    if (leds !== 4'd4) begin
      failures++;
      $display("FAIL basic_den leds=%0d expected=4", leds);
    end
    run_division("basic");
  endtask

  task automatic test_div_zero();
    int s0;
    move_val(7, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    m_den = 0;
    s0 = starts;
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (err !== 1'b1 || leds !== 4'hF || starts !== s0) begin
      failures++;
      $display("FAIL div_zero err=%b leds=%0h starts=%0d expected err=1 leds=f starts=%0d",
               err, leds, starts, s0);
    end
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (err !== 1'b0 || leds !== 4'd0) begin
      failures++;
      $display("FAIL div_zero_recover err=%b leds=%0d expected err=0 leds=0", err, leds);
    end
    move_val(2, 1'b1);
    run_division("after_zero");
  endtask

  task automatic test_wrap();
    move_val(0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    checks++;
    if (leds !== 4'd15) begin
      failures++;
      $display("FAIL wrap_down leds=%0d expected=15", leds);
    end
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if (leds !== 4'd0) begin
      failures++;
      $display("FAIL wrap_up leds=%0d expected=0", leds);
    end
    press(1'b1, 1'b1, 1'b0);
    m_num = 0;
    checks++;
    if (leds !== 4'd0) begin
      failures++;
      $display("FAIL up_down_same leds=%0d expected=0", leds);
    end
  endtask

  task automatic test_random_div();
    int tn, td;
    for (int it = 0; it < 5; it++) begin
      tn = $urandom_range(0, 15);
      td = $urandom_range(1, 15);
      move_val(tn, 1'b0);
      press(1'b0, 1'b0, 1'b1);
      m_den = 0;
      checks++;
      if (leds !== 4'd0) begin
        failures++;
        $display("FAIL rand_den_clear leds=%0d expected=0", leds);
      end
      move_val(td, 1'b1);
      run_division("random");
    end
  endtask

  task automatic test_reset_in_wait();
    bit found;
    move_val(9, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    m_den = 0;
    move_val(2, 1'b1);
    @(negedge clk);
    ok = 1'b1;
    wait_start(found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rst_wait_start got=0 expected=1");
    end
    @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_wait_busy got=%b expected=1", busy);
    end
    rst = 1'b0;
    ok  = 1'b0;
    #1;
    checks++;
    if (leds !== 4'd0 || busy !== 1'b0 || dv_if.dv_start !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL rst_async leds=%0d busy=%b start=%b err=%b expected all zero",
               leds, busy, dv_if.dv_start, err);
    end
    @(negedge clk);
    rst = 1'b1;
    m_num = 0;
    m_den = 0;
    repeat (15) @(negedge clk);
    checks++;
    if (leds !== 4'd0 || busy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL late_done_ignored leds=%0d busy=%b err=%b expected 0/0/0", leds, busy, err);
    end
  endtask

  task automatic test_timeout();
    bit found;
    dp_en = 1'b0;
    move_val(5, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    m_den = 0;
    move_val(3, 1'b1);
    @(negedge clk);
    ok = 1'b1;
    wait_start(found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL timeout_start got=0 expected=1");
    end
    repeat (TIMEOUT) @(posedge clk);
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early err=%b busy=%b expected err=0 busy=1", err, busy);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || leds !== 4'hF || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_expiry err=%b leds=%0h busy=%b expected err=1 leds=f busy=0",
               err, leds, busy);
    end
    ok = 1'b0;
    repeat (SETTLE) @(negedge clk);
    dp_en = 1'b1;
    do_reset();
  endtask

`ifdef DEBOUNCE_EN
  task automatic test_debounce();
    @(negedge clk);
    up = 1'b1;
    repeat (DEB_CYCLES - 1) @(negedge clk);
    up = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (leds !== m_num[3:0]) begin
      failures++;
      $display("FAIL deb_short_glitch leds=%0d expected=%0d", leds, m_num);
    end
    @(negedge clk);
    up = 1'b1;
    repeat (DEB_CYCLES) @(negedge clk);
    up = 1'b0;
    repeat (40) @(negedge clk);
    m_num = (m_num + 1) % 16;
    checks++;
    if (leds !== m_num[3:0]) begin
      failures++;
      $display("FAIL deb_accept leds=%0d expected=%0d", leds, m_num);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_wrap();
    test_random_div();
    test_reset_in_wait();
    test_timeout();
`ifdef DEBOUNCE_EN
    test_debounce();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
